// File: rtl/can_fault_confinement_pkg.sv
// Shared types, default limits and configuration checks for the CAN
// fault-confinement unit.
package can_fc_pkg;

   typedef enum logic [1:0] {
      ERROR_ACTIVE  = 2'b00,
      ERROR_PASSIVE = 2'b01,
      BUS_OFF       = 2'b10
   } fault_state_e;

   localparam int DEF_CNT_W          = 9;
   localparam int DEF_TX_ERR_INC     = 8;
   localparam int DEF_RX_ERR_INC     = 1;
   localparam int DEF_RX_PRIMARY_INC = 8;
   localparam int DEF_WARN_LIMIT     = 96;
   localparam int DEF_PASSIVE_LIMIT  = 128;
   localparam int DEF_BUSOFF_LIMIT   = 256;
   localparam int DEF_REC_RELOAD     = 120;
   localparam int DEF_RECOVERY_SEQS  = 128;

   // The counter must hold 256 and the reload value must sit just below the
   // passive threshold; recovery_count is 8 bits wide.
   function automatic bit cfg_ok(int cnt_w, int rec_reload, int recovery_seqs);
      return (cnt_w >= 9) && (rec_reload >= 119) && (rec_reload <= 127) &&
             (recovery_seqs >= 1) && (recovery_seqs <= 256);
   endfunction

endpackage

// File: rtl/can_fault_confinement_if.sv
// Event/status bundle between the error-detection logic, the protocol
// controller (master side) and the fault-confinement unit (slave side).
interface can_fault_confinement_if #(
   parameter int CNT_W = 9
);
   import can_fc_pkg::*;

   logic             enable;
   logic             error_detected;
   logic             primary_error;
   logic             tx_success;
   logic             rx_success;
   logic             transmitting;
   logic             recessive_11;
   logic [CNT_W-1:0] tec;
   logic [CNT_W-1:0] rec;
   fault_state_e     fault_state;
   logic             error_warning;
   logic             bus_off_recovered;
   logic [7:0]       recovery_count;

   modport master (
      output enable, error_detected, primary_error, tx_success, rx_success,
             transmitting, recessive_11,
      input  tec, rec, fault_state, error_warning, bus_off_recovered,
             recovery_count
   );

   modport slave (
      input  enable, error_detected, primary_error, tx_success, rx_success,
             transmitting, recessive_11,
      output tec, rec, fault_state, error_warning, bus_off_recovered,
             recovery_count
   );

endinterface

// File: rtl/can_fault_confinement_sat_counter.sv
// Saturating up/down error counter with clear, load and variable increment.
// Priority: clear, load, increment, decrement; decrement stops at zero.
module can_err_sat_counter #(
   parameter int W   = 9,
   parameter int MAX = (1 << W) - 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] inc_amt,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic [W-1:0] count_next
);

   logic [W-1:0] count_q, count_d;
   logic [W:0]   sum;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      sum     = {1'b0, count_q} + {1'b0, inc_amt};
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (load)
         count_d = load_val;
      else if (inc)
         count_d = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
      else if (dec && (count_q != '0))
         count_d = count_q - W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/can_fault_confinement.sv
// CAN fault confinement: TEC/REC counters, active/passive/bus-off state,
// error warning and bus-off recovery after RECOVERY_SEQS recessive_11 pulses.
module can_fault_confinement
   import can_fc_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TX_ERR_INC     = DEF_TX_ERR_INC,
   parameter int RX_ERR_INC     = DEF_RX_ERR_INC,
   parameter int RX_PRIMARY_INC = DEF_RX_PRIMARY_INC,
   parameter int WARN_LIMIT     = DEF_WARN_LIMIT,
   parameter int PASSIVE_LIMIT  = DEF_PASSIVE_LIMIT,
   parameter int BUSOFF_LIMIT   = DEF_BUSOFF_LIMIT,
   parameter int REC_RELOAD     = DEF_REC_RELOAD,
   parameter int RECOVERY_SEQS  = DEF_RECOVERY_SEQS
) (
   input  logic                    clock,
   input  logic                    reset,
   can_fault_confinement_if.slave  bus
);

   if (!cfg_ok(CNT_W, REC_RELOAD, RECOVERY_SEQS)) begin : g_cfg_check
      $error("can_fault_confinement: illegal CNT_W/REC_RELOAD/RECOVERY_SEQS");
   end

   fault_state_e     state_q, state_d;
   logic             warn_q, warn_d;
   logic             recovered_q, recovered_d;
   logic [7:0]       rcnt_q, rcnt_d;
   logic [CNT_W-1:0] tec, rec, tec_next, rec_next;
   logic             in_bus_off, live, tx_err, tx_ok, rx_err, rx_ok;
   logic             rec_reload, recover, clear_cnt;

   // Errors beat successes; the transmitting flag picks which counter moves.
   assign in_bus_off = (state_q == BUS_OFF);
   assign live       = bus.enable && !in_bus_off;
   assign tx_err     = live &&  bus.transmitting && bus.error_detected;
   assign tx_ok      = live &&  bus.transmitting && !bus.error_detected && bus.tx_success;
   assign rx_err     = live && !bus.transmitting && bus.error_detected;
   assign rx_ok      = live && !bus.transmitting && !bus.error_detected && bus.rx_success;
   assign rec_reload = rx_ok && (rec >= CNT_W'(PASSIVE_LIMIT));
   assign recover    = bus.enable && in_bus_off && bus.recessive_11 &&
                       (rcnt_q == 8'(RECOVERY_SEQS - 1));
   assign clear_cnt  = !bus.enable || recover;

   can_err_sat_counter #(.W(CNT_W), .MAX(BUSOFF_LIMIT)) u_tec (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear_cnt),
      .load       (1'b0),
      .load_val   ('0),
      .inc        (tx_err),
      .inc_amt    (CNT_W'(TX_ERR_INC)),
      .dec        (tx_ok),
      .count      (tec),
      .count_next (tec_next)
   );

   can_err_sat_counter #(.W(CNT_W), .MAX((1 << CNT_W) - 1)) u_rec (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear_cnt),
      .load       (rec_reload),
      .load_val   (CNT_W'(REC_RELOAD)),
      .inc        (rx_err),
      .inc_amt    (bus.primary_error ? CNT_W'(RX_PRIMARY_INC) : CNT_W'(RX_ERR_INC)),
      .dec        (rx_ok && !rec_reload),
      .count      (rec),
      .count_next (rec_next)
   );

   // State and warning follow the next counter values so they line up with
   // tec/rec in the same cycle.
   always_comb begin
      state_d     = state_q;
      recovered_d = recover;
      rcnt_d      = rcnt_q;
      if (clear_cnt)
         state_d = ERROR_ACTIVE;
      else if (!in_bus_off) begin
         if (tec_next >= CNT_W'(BUSOFF_LIMIT))
            state_d = BUS_OFF;
         else if ((tec_next >= CNT_W'(PASSIVE_LIMIT)) || (rec_next >= CNT_W'(PASSIVE_LIMIT)))
            state_d = ERROR_PASSIVE;
         else
            state_d = ERROR_ACTIVE;
      end
      if (clear_cnt || !in_bus_off)
         rcnt_d = '0;
      else if (bus.recessive_11)
         rcnt_d = rcnt_q + 8'd1;
      warn_d = (state_d == BUS_OFF) ||
               (tec_next >= CNT_W'(WARN_LIMIT)) || (rec_next >= CNT_W'(WARN_LIMIT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ERROR_ACTIVE;
         warn_q      <= 1'b0;
         recovered_q <= 1'b0;
         rcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         warn_q      <= warn_d;
         recovered_q <= recovered_d;
         rcnt_q      <= rcnt_d;
      end
   end

   assign bus.tec               = tec;
   assign bus.rec               = rec;
   assign bus.fault_state       = state_q;
   assign bus.error_warning     = warn_q;
   assign bus.bus_off_recovered = recovered_q;
   assign bus.recovery_count    = rcnt_q;

endmodule

// File: doc/can_fault_confinement.md
Name: can_fault_confinement

Overview:
Parametrised CAN fault-confinement unit: the next generation of the per-node TX/RX error counter.
- Holds the transmit error counter (TEC) and receive error counter (REC) at configurable width and step sizes.
- Implements the full error-active / error-passive / bus-off state machine, an error-warning flag, the REC reload rule and bus-off recovery.
- Sits between the error-detection logic (event pulses in) and the protocol controller (state and counters out).

Parameters:
CNT_W, 9, counter width; must be >= 9 so that 256 is representable
TX_ERR_INC, 8, TEC step per transmit error
RX_ERR_INC, 1, REC step per ordinary receive error
RX_PRIMARY_INC, 8, REC step per receive error flagged primary
WARN_LIMIT, 96, error_warning threshold
PASSIVE_LIMIT, 128, error-passive threshold
BUSOFF_LIMIT, 256, TEC bus-off threshold
REC_RELOAD, 120, REC value after rx_success while REC >= PASSIVE_LIMIT; must be 119..127
RECOVERY_SEQS, 128, recessive_11 pulses required to leave bus-off

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
enable  input  1  low = synchronous clear of all state
error_detected  input  1  one-cycle error event
primary_error  input  1  qualifies error_detected as primary (RX step RX_PRIMARY_INC)
tx_success  input  1  one-cycle successful-transmit pulse
rx_success  input  1  one-cycle successful-receive pulse
transmitting  input  1  high = node is transmitter; selects TEC vs REC
recessive_11  input  1  pulse per 11 consecutive recessive bits observed
tec  output  CNT_W  transmit error counter
rec  output  CNT_W  receive error counter
fault_state  output  2  fault_state_e: ERROR_ACTIVE / ERROR_PASSIVE / BUS_OFF
error_warning  output  1  tec or rec >= WARN_LIMIT
bus_off_recovered  output  1  one-cycle pulse on bus-off exit
recovery_count  output  8  recessive_11 pulses counted while in bus-off

Behaviour:
Reset and enable:
- Async reset: tec=0, rec=0, fault_state=ERROR_ACTIVE, error_warning=0, bus_off_recovered=0, recovery_count=0.
- enable=0 forces the same values synchronously and ignores all inputs.

Timing:
- All outputs are registered; 1-cycle latency from event to updated value.
- fault_state and error_warning are computed from the next counter values, so they are always consistent with tec/rec in the same cycle.

Event priority (same cycle):
- error_detected beats success: the increment is applied and tx_success/rx_success are ignored.
- transmitting=1: only TEC is affected and rx_success is ignored.
- transmitting=0: only REC is affected and tx_success is ignored.

TEC (not in bus-off):
- On error: tec += TX_ERR_INC.
- If the sum is >= BUSOFF_LIMIT, tec = BUSOFF_LIMIT and the state goes to BUS_OFF.
- On tx_success: decrement if > 0; stays at 0 otherwise.

REC:
- On error: rec += (primary_error ? RX_PRIMARY_INC : RX_ERR_INC), saturating at 2^CNT_W-1. REC never causes bus-off.
- On rx_success: if rec >= PASSIVE_LIMIT, rec = REC_RELOAD; else if rec > 0, decrement.

State machine:
- ERROR_ACTIVE <-> ERROR_PASSIVE: PASSIVE when (tec >= PASSIVE_LIMIT or rec >= PASSIVE_LIMIT), else ACTIVE.
- ERROR_ACTIVE or ERROR_PASSIVE -> BUS_OFF: when tec reaches BUSOFF_LIMIT.

BUS_OFF:
- error_detected and the success inputs are ignored; tec and rec are frozen; error_warning=1.
- Each recessive_11 pulse increments recovery_count.
- On the pulse that makes the count RECOVERY_SEQS, in that same update:
  - tec=0, rec=0, recovery_count=0
  - fault_state=ERROR_ACTIVE
  - bus_off_recovered=1 for exactly one cycle.
- recessive_11 outside BUS_OFF is ignored and recovery_count holds at 0.

Other rules:
- primary_error without error_detected has no effect.
- Reset or enable=0 mid-recovery discards all progress.

Decomposition:
- Package can_fc_pkg:
  - fault_state_e enum (ERROR_ACTIVE=2'b00, ERROR_PASSIVE=2'b01, BUS_OFF=2'b10)
  - default limit/step localparams
  - CNT_W >= 9 and REC_RELOAD range elaboration checks
- Sub-module can_err_sat_counter: parametrised saturating up/down counter with an increment-amount input, a clear input and a load input. Instantiated once for TEC and once for REC; the state machine stays in the top module.

Test Plan:
1. Reset: assert reset mid-cycle -> immediately tec=0, rec=0, fault_state=ERROR_ACTIVE, error_warning=0; enable=0 for one cycle -> same values.
2. TEC to passive: 12 TX errors (transmitting=1) -> tec=96, error_warning=1, ACTIVE; 4 more -> tec=128, ERROR_PASSIVE; 1 tx_success -> tec=127, ERROR_ACTIVE.
3. Bus-off and recovery:
   - 32 TX errors -> tec=256, BUS_OFF.
   - Further errors and tx_success -> tec stays 256.
   - 127 recessive_11 pulses -> still BUS_OFF, recovery_count=127.
   - 128th pulse -> tec=rec=0, ERROR_ACTIVE, bus_off_recovered high exactly one cycle.
4. REC reload: 17 primary RX errors -> rec=136, ERROR_PASSIVE; rx_success -> rec=120, ERROR_ACTIVE; next rx_success -> rec=119.
5. Simultaneous events: tec=10, transmitting=1, error_detected and tx_success in the same cycle -> tec=18; rec=0 with rx_success -> rec stays 0.
6. Reset mid-recovery: BUS_OFF with recovery_count=60, assert reset -> recovery_count=0, ERROR_ACTIVE, no bus_off_recovered pulse.
